multicycle_main_control: RTL and testbench

- Main control FSM for the multicycle RISC-V datapath.
- Sits directly upstream of the ALU control decoder and drives its alu_op0/alu_op1 inputs.
- Also drives PC, IR, register-file, memory and mux-select strobes for each instruction step.
- Handles variable memory latency through a mem_ready handshake and keeps a retired-instruction counter.

---
 rtl/multicycle_main_control_if.sv | 37 +++
 rtl/multicycle_main_control.sv | 163 ++++++++++++++++
 tb/tb_multicycle_main_control.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multicycle main FSM and the datapath it steers.
interface multicycle_main_control_if #(
   parameter int unsigned COUNT_W = 32
);
   logic [6:0]         opcode;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic [1:0]         pc_source;
   logic               i_or_d;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic [1:0]         mem_to_reg;
   logic               reg_write;
   logic [1:0]         alu_src_a;
   logic [1:0]         alu_src_b;
   logic               alu_op0;
   logic               alu_op1;
   logic               illegal;
   logic [3:0]         state_out;
   logic [COUNT_W-1:0] instr_count;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op0, alu_op1, illegal,
             state_out, instr_count
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op0, alu_op1, illegal,
             state_out, instr_count
   );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RISC-V datapath, with mem_ready stalls and a
// retired-instruction counter.
module multicycle_main_control #(
   parameter int unsigned COUNT_W = 32
) (
   input logic                      i_clk,
   input logic                      i_rst,
   multicycle_main_control_if.master bus
);
   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAddr  = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9,
      StJal      = 4'd10,
      StTrap     = 4'd15
   } state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpIType  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;

   state_e             r_state;
   logic [COUNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StFetch;
         r_count <= '0;
      end else begin
         unique case (r_state)
            StFetch:    if (bus.mem_ready) r_state <= StDecode;
            StDecode: begin
               unique case (bus.opcode)
                  OpLoad, OpStore: r_state <= StMemAddr;
                  OpRType:         r_state <= StExecR;
                  OpIType:         r_state <= StExecI;
                  OpBranch:        r_state <= StBranch;
                  OpJal:           r_state <= StJal;
                  default:         r_state <= StTrap;
               endcase
            end
            StMemAddr:  r_state <= (bus.opcode == OpStore) ? StMemWrite : StMemRead;
            StMemRead:  if (bus.mem_ready) r_state <= StMemWb;
            StMemWrite: if (bus.mem_ready) r_state <= StFetch;
            StExecR, StExecI: r_state <= StAluWb;
            StMemWb, StAluWb, StBranch, StJal: r_state <= StFetch;
            StTrap:     r_state <= StTrap;
            default:    r_state <= StTrap;
         endcase
         // Every path from a retiring state back to FETCH counts one instruction.
         if ((r_state == StMemWb) || (r_state == StAluWb) || (r_state == StBranch) ||
             (r_state == StJal) || ((r_state == StMemWrite) && bus.mem_ready)) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   logic       w_pc_write;
   logic       w_pc_write_cond;
   logic [1:0] w_pc_source;
   logic       w_i_or_d;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_ir_write;
   logic [1:0] w_mem_to_reg;
   logic       w_reg_write;
   logic [1:0] w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_alu_op;
   logic       w_illegal;

   always_comb begin
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_pc_source     = 2'b00;
      w_i_or_d        = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_ir_write      = 1'b0;
      w_mem_to_reg    = 2'b00;
      w_reg_write     = 1'b0;
      w_alu_src_a     = 2'b00;
      w_alu_src_b     = 2'b00;
      w_alu_op        = 2'b00;
      w_illegal       = 1'b0;
      unique case (r_state)
         StFetch: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = 2'b01;
            w_ir_write  = bus.mem_ready;
            w_pc_write  = bus.mem_ready;
         end
         StDecode:   w_alu_src_b = 2'b11;
         StMemAddr: begin
            w_alu_src_a = 2'b01;
            w_alu_src_b = 2'b10;
         end
         StMemRead: begin
            w_mem_read = 1'b1;
            w_i_or_d   = 1'b1;
         end
         StMemWb: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 2'b01;
         end
         StMemWrite: begin
            w_mem_write = 1'b1;
            w_i_or_d    = 1'b1;
         end
         StExecR: begin
            w_alu_src_a = 2'b01;
            w_alu_op    = 2'b10;
         end
         StExecI: begin
            w_alu_src_a = 2'b01;
            w_alu_src_b = 2'b10;
         end
         StAluWb:    w_reg_write = 1'b1;
         StBranch: begin
            w_alu_src_a     = 2'b01;
            w_alu_op        = 2'b01;
            w_pc_write_cond = 1'b1;
            w_pc_source     = 2'b01;
         end
         StJal: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 2'b10;
            w_pc_write   = 1'b1;
            w_pc_source  = 2'b01;
         end
         StTrap:     w_illegal = 1'b1;
         default:    w_illegal = 1'b0;
      endcase
   end

   // Write strobes are gated by rst so an abandoned instruction never commits.
   assign bus.pc_write      = w_pc_write & ~i_rst;
   assign bus.pc_write_cond = w_pc_write_cond & ~i_rst;
   assign bus.ir_write      = w_ir_write & ~i_rst;
   assign bus.reg_write     = w_reg_write & ~i_rst;
   assign bus.mem_write     = w_mem_write & ~i_rst;
   assign bus.pc_source     = w_pc_source;
   assign bus.i_or_d        = w_i_or_d;
   assign bus.mem_read      = w_mem_read;
   assign bus.mem_to_reg    = w_mem_to_reg;
   assign bus.alu_src_a     = w_alu_src_a;
   assign bus.alu_src_b     = w_alu_src_b;
   assign bus.alu_op0       = w_alu_op[0];
   assign bus.alu_op1       = w_alu_op[1];
   assign bus.illegal       = w_illegal;
   assign bus.state_out     = r_state;
   assign bus.instr_count   = r_count;
endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control; runs with a 4-bit counter so wrap is reachable.
module tb_multicycle_main_control;
   localparam int unsigned CW = 4;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic [CW-1:0] exp_count;

   multicycle_main_control_if #(.COUNT_W(CW)) bus ();

   multicycle_main_control #(.COUNT_W(CW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are changed 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.mem_ready = 1'b0;
      bus.opcode = 7'b0000000;
      tick();
      tick();
      #1;
      total++;
      if (bus.state_out !== 4'd0) begin
         bad++; $display("FAIL reset_state: got %0d want 0", bus.state_out);
      end
      total++;
      if (bus.instr_count !== 4'd0) begin
         bad++; $display("FAIL reset_count: got %0d want 0", bus.instr_count);
      end
      total++;
      if ({bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.mem_write}
          !== 5'b0) begin
         bad++; $display("FAIL reset_strobes: got %b want 00000",
            {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.mem_write});
      end
      total++;
      if (bus.mem_read !== 1'b1) begin
         bad++; $display("FAIL reset_mem_read: got %b want 1", bus.mem_read);
      end
      bus.mem_ready = 1'b1;
      #1;
      total++;
      if ({bus.ir_write, bus.pc_write} !== 2'b00) begin
         bad++; $display("FAIL reset_mask_ready: got %b want 00", {bus.ir_write, bus.pc_write});
      end
      tick();
      rst = 1'b0;
      bus.mem_ready = 1'b0;
      exp_count = '0;
   endtask

   task automatic test_rtype();
      logic [3:0] st [5];
      logic       rw [5];
      st = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
      rw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      bus.opcode = 7'b0110011;
      bus.mem_ready = 1'b1;
      #1;
      total++;
      if ({bus.ir_write, bus.pc_write, bus.alu_src_b} !== 4'b1101) begin
         bad++; $display("FAIL rtype_fetch: got %b want 1101",
            {bus.ir_write, bus.pc_write, bus.alu_src_b});
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({bus.state_out, bus.reg_write} !== {st[i], rw[i]}) begin
            bad++; $display("FAIL rtype_step%0d: got state=%0d rw=%b want state=%0d rw=%b",
               i, bus.state_out, bus.reg_write, st[i], rw[i]);
         end
         if (i == 2) begin
            total++;
            if ({bus.alu_op1, bus.alu_op0, bus.alu_src_a, bus.alu_src_b} !== 6'b100100) begin
               bad++; $display("FAIL rtype_exec: got %b want 100100",
                  {bus.alu_op1, bus.alu_op0, bus.alu_src_a, bus.alu_src_b});
            end
         end
         if (i < 4) tick();
      end
      exp_count = exp_count + 1'b1;
      total++;
      if (bus.instr_count !== exp_count) begin
         bad++; $display("FAIL rtype_count: got %0d want %0d", bus.instr_count, exp_count);
      end
   endtask

   task automatic test_lw_wait();
      logic [3:0] st  [10];
      logic       rdy [10];
      logic       irw [10];
      logic       mrd [10];
      st  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
      rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      irw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      mrd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      bus.opcode = 7'b0000011;
      for (int i = 0; i < 10; i++) begin
         bus.mem_ready = rdy[i];
         #1;
         total++;
         if ({bus.state_out, bus.ir_write, bus.mem_read} !== {st[i], irw[i], mrd[i]}) begin
            bad++; $display("FAIL lw_step%0d: got st=%0d irw=%b mrd=%b want st=%0d irw=%b mrd=%b",
               i, bus.state_out, bus.ir_write, bus.mem_read, st[i], irw[i], mrd[i]);
         end
         if (i == 4) begin
            total++;
            if ({bus.alu_src_a, bus.alu_src_b} !== 4'b0110) begin
               bad++; $display("FAIL lw_addr_srcs: got %b want 0110",
                  {bus.alu_src_a, bus.alu_src_b});
            end
         end
         if (i >= 5 && i <= 8) begin
            total++;
            if ({bus.i_or_d, bus.reg_write} !== 2'b10) begin
               bad++; $display("FAIL lw_wait%0d: got iord/rw=%b want 10",
                  i, {bus.i_or_d, bus.reg_write});
            end
         end
         if (i == 9) begin
            total++;
            if ({bus.reg_write, bus.mem_to_reg} !== 3'b101) begin
               bad++; $display("FAIL lw_wb: got %b want 101", {bus.reg_write, bus.mem_to_reg});
            end
         end
         tick();
      end
      exp_count = exp_count + 1'b1;
      total++;
      if ({bus.state_out, bus.instr_count} !== {4'd0, exp_count}) begin
         bad++; $display("FAIL lw_retire: got st=%0d cnt=%0d want st=0 cnt=%0d",
            bus.state_out, bus.instr_count, exp_count);
      end
   endtask

   task automatic test_beq_jal();
      bus.mem_ready = 1'b1;
      bus.opcode = 7'b1100011;
      tick();
      tick();
      total++;
      if ({bus.state_out, bus.alu_op1, bus.alu_op0, bus.pc_write_cond, bus.pc_source,
           bus.pc_write} !== {4'd9, 2'b01, 1'b1, 2'b01, 1'b0}) begin
         bad++; $display("FAIL beq_branch: got st=%0d op=%b%b pwc=%b psrc=%b pw=%b",
            bus.state_out, bus.alu_op1, bus.alu_op0, bus.pc_write_cond, bus.pc_source,
            bus.pc_write);
      end
      tick();
      bus.opcode = 7'b1101111;
      tick();
      tick();
      total++;
      if ({bus.state_out, bus.pc_write, bus.reg_write, bus.mem_to_reg, bus.pc_source,
           bus.pc_write_cond} !== {4'd10, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0}) begin
         bad++; $display("FAIL jal_step: got st=%0d pw=%b rw=%b m2r=%b psrc=%b pwc=%b",
            bus.state_out, bus.pc_write, bus.reg_write, bus.mem_to_reg, bus.pc_source,
            bus.pc_write_cond);
      end
      tick();
      exp_count = exp_count + 2'd2;
      total++;
      if ({bus.state_out, bus.instr_count} !== {4'd0, exp_count}) begin
         bad++; $display("FAIL beq_jal_count: got st=%0d cnt=%0d want st=0 cnt=%0d",
            bus.state_out, bus.instr_count, exp_count);
      end
   endtask

   task automatic test_illegal();
      int errs;
      errs = 0;
      bus.mem_ready = 1'b1;
      bus.opcode = 7'b1111111;
      tick();
      tick();
      for (int i = 0; i < 20; i++) begin
         bus.mem_ready = i[0];
         #1;
         if ({bus.state_out, bus.illegal, bus.mem_read, bus.ir_write, bus.pc_write,
              bus.reg_write, bus.mem_write, bus.instr_count}
             !== {4'd15, 1'b1, 5'b0, exp_count}) begin
            errs++;
            $display("FAIL trap_hold%0d: got st=%0d ill=%b mrd=%b cnt=%0d want st=15 ill=1 cnt=%0d",
               i, bus.state_out, bus.illegal, bus.mem_read, bus.instr_count, exp_count);
         end
         tick();
      end
      total++;
      if (errs != 0) bad++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.mem_ready = 1'b0;
      exp_count = '0;
      #1;
      total++;
      if ({bus.state_out, bus.illegal, bus.instr_count} !== {4'd0, 1'b0, exp_count}) begin
         bad++; $display("FAIL trap_exit: got st=%0d ill=%b cnt=%0d want st=0 ill=0 cnt=0",
            bus.state_out, bus.illegal, bus.instr_count);
      end
   endtask

   task automatic test_sw_reset();
      bus.opcode = 7'b0100011;
      bus.mem_ready = 1'b1;
      tick();
      tick();
      tick();
      bus.mem_ready = 1'b0;
      #1;
      total++;
      if ({bus.state_out, bus.mem_write, bus.i_or_d, bus.mem_read} !== {4'd5, 3'b110}) begin
         bad++; $display("FAIL sw_wait: got st=%0d mw=%b iord=%b mrd=%b want st=5 110",
            bus.state_out, bus.mem_write, bus.i_or_d, bus.mem_read);
      end
      tick();
      bus.mem_ready = 1'b1;
      tick();
      exp_count = exp_count + 1'b1;
      total++;
      if ({bus.state_out, bus.instr_count} !== {4'd0, exp_count}) begin
         bad++; $display("FAIL sw_retire: got st=%0d cnt=%0d want st=0 cnt=%0d",
            bus.state_out, bus.instr_count, exp_count);
      end
      tick();
      tick();
      tick();
      bus.mem_ready = 1'b0;
      tick();
      rst = 1'b1;
      bus.mem_ready = 1'b1;
      #1;
      total++;
      if ({bus.state_out, bus.mem_write} !== {4'd5, 1'b0}) begin
         bad++; $display("FAIL sw_rst_strobe: got st=%0d mw=%b want st=5 mw=0",
            bus.state_out, bus.mem_write);
      end
      tick();
      rst = 1'b0;
      bus.mem_ready = 1'b0;
      exp_count = '0;
      #1;
      total++;
      if ({bus.state_out, bus.instr_count} !== {4'd0, exp_count}) begin
         bad++; $display("FAIL sw_rst_after: got st=%0d cnt=%0d want st=0 cnt=0",
            bus.state_out, bus.instr_count);
      end
   endtask

   task automatic test_wrap();
      bus.opcode = 7'b0110011;
      bus.mem_ready = 1'b1;
      for (int n = 0; n < 16; n++) begin
         for (int c = 0; c < 4; c++) tick();
         exp_count = exp_count + 1'b1;
         total++;
         if (bus.instr_count !== exp_count) begin
            bad++; $display("FAIL wrap_instr%0d: got %0d want %0d",
               n, bus.instr_count, exp_count);
         end
      end
      total++;
      if (bus.instr_count !== 4'd0) begin
         bad++; $display("FAIL wrap_zero: got %0d want 0", bus.instr_count);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      bus.opcode = 7'b0;
      bus.mem_ready = 1'b0;
      exp_count = '0;
      #2;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_beq_jal();
      test_illegal();
      test_sw_reset();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
